// File: rtl/mant_align.sv
// Mantissa alignment stage for FP add/sub: swaps operands by exponent order, then right-shifts
// the smaller significand into a {significand, G, R, S} word. Two register stages, valid/ready on both sides.
module mant_align #(
   parameter int ex_width  = 8,
   parameter int man_width = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [man_width:0]     Ma,
   input  logic [man_width:0]     Mb,
   input  logic [ex_width:0]      d,
   input  logic                   sign_exp,
   input  logic [ex_width-1:0]    max_exp,
   input  logic                   op_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [man_width:0]     m_big,
   output logic [man_width+3:0]   m_small_al,
   output logic [ex_width-1:0]    exp_out,
   output logic                   swap,
   output logic                   op_out
);

   localparam int W   = man_width + 4;
   localparam int SHW = $clog2(W + 1);

   // Handshake: a transfer happens on a rising edge where valid && ready are both 1; valid never
   // depends on ready, and a stalled output (out_valid && !out_ready) holds every output stable.
   logic                 s1_v_q, s1_v_d, s2_v_q, s2_v_d;
   logic [man_width:0]   big_q, big_d, small_q, small_d;
   logic [SHW-1:0]       sh_q, sh_d;
   logic [ex_width-1:0]  exp1_q, exp1_d, exp2_q, exp2_d;
   logic                 swap1_q, swap1_d, swap2_q, swap2_d;
   logic                 op1_q, op1_d, op2_q, op2_d;
   logic [man_width:0]   m_big_q, m_big_d;
   logic [W-1:0]         m_small_al_q, m_small_al_d;
   logic                 adv2, accept;
   logic [W-1:0]         ext, shifted, lost_mask;
   logic                 lost;

   always_comb begin
      adv2     = s1_v_q && (!s2_v_q || out_ready);
      in_ready = !rst && (!s1_v_q || adv2);
      accept   = in_valid && in_ready;

      s1_v_d  = accept || (s1_v_q && !adv2);
      big_d   = big_q;
      small_d = small_q;
      sh_d    = sh_q;
      exp1_d  = exp1_q;
      swap1_d = swap1_q;
      op1_d   = op1_q;
      if (accept) begin
         big_d   = sign_exp ? Mb : Ma;
         small_d = sign_exp ? Ma : Mb;
         // Any difference of W or more shifts everything into the sticky bit.
         sh_d    = (d >= (ex_width + 1)'(W)) ? SHW'(W) : d[SHW-1:0];
         exp1_d  = max_exp;
         swap1_d = sign_exp;
         op1_d   = op_in;
      end

      ext       = {small_q, 3'b000};
      shifted   = ext >> sh_q;
      lost_mask = ~({W{1'b1}} << sh_q);
      lost      = |(ext & lost_mask);

      s2_v_d       = adv2 || (s2_v_q && !out_ready);
      m_big_d      = m_big_q;
      m_small_al_d = m_small_al_q;
      exp2_d       = exp2_q;
      swap2_d      = swap2_q;
      op2_d        = op2_q;
      if (adv2) begin
         m_big_d      = big_q;
         m_small_al_d = {shifted[W-1:1], shifted[0] | lost};
         exp2_d       = exp1_q;
         swap2_d      = swap1_q;
         op2_d        = op1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v_q       <= 1'b0;
         s2_v_q       <= 1'b0;
         big_q        <= '0;
         small_q      <= '0;
         sh_q         <= '0;
         exp1_q       <= '0;
         swap1_q      <= 1'b0;
         op1_q        <= 1'b0;
         m_big_q      <= '0;
         m_small_al_q <= '0;
         exp2_q       <= '0;
         swap2_q      <= 1'b0;
         op2_q        <= 1'b0;
      end else begin
         s1_v_q       <= s1_v_d;
         s2_v_q       <= s2_v_d;
         big_q        <= big_d;
         small_q      <= small_d;
         sh_q         <= sh_d;
         exp1_q       <= exp1_d;
         swap1_q      <= swap1_d;
         op1_q        <= op1_d;
         m_big_q      <= m_big_d;
         m_small_al_q <= m_small_al_d;
         exp2_q       <= exp2_d;
         swap2_q      <= swap2_d;
         op2_q        <= op2_d;
      end
   end

   assign out_valid  = s2_v_q;
   assign m_big      = m_big_q;
   assign m_small_al = m_small_al_q;
   assign exp_out    = exp2_q;
   assign swap       = swap2_q;
   assign op_out     = op2_q;

endmodule

// File: tb/tb_mant_align.sv
// Directed bench for mant_align: alignment vectors, saturation, streaming, backpressure and reset.
module tb_mant_align;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [23:0] Ma, Mb;
   logic [8:0]  d;
   logic        sign_exp;
   logic [7:0]  max_exp;
   logic        op_in;
   logic        out_valid, out_ready;
   logic [23:0] m_big;
   logic [26:0] m_small_al;
   logic [7:0]  exp_out;
   logic        swap, op_out;

   int n_cmp = 0;
   int n_err = 0;
   logic [50:0] exp_q[$];

   mant_align #(.ex_width(8), .man_width(23)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .Ma(Ma), .Mb(Mb), .d(d), .sign_exp(sign_exp), .max_exp(max_exp), .op_in(op_in),
      .out_valid(out_valid), .out_ready(out_ready), .m_big(m_big), .m_small_al(m_small_al),
      .exp_out(exp_out), .swap(swap), .op_out(op_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [23:0] a, input logic [23:0] b, input logic [8:0] dd,
                         input logic se, input logic [7:0] me, input logic op);
      Ma = a; Mb = b; d = dd; sign_exp = se; max_exp = me; op_in = op;
   endtask

   // Drives one transaction with out_ready=1 and leaves it sitting on the output.
   task automatic send_one(input logic [23:0] a, input logic [23:0] b, input logic [8:0] dd,
                           input logic se, input logic [7:0] me, input logic op);
      set_in(a, b, dd, se, me, op);
      in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL lat1_valid: got %b want 0", out_valid);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_err++; $display("FAIL lat2_valid: got %b want 1", out_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      set_in(24'h0, 24'h0, 9'h0, 1'b0, 8'h0, 1'b0);
      tick(); tick();
      rst = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || m_big !== 24'h0 || m_small_al !== 27'h0 || exp_out !== 8'h0 ||
          swap !== 1'b0 || op_out !== 1'b0) begin
         n_err++; $display("FAIL reset_outputs: got v=%b big=%h al=%h e=%h sw=%b op=%b want all 0",
                           out_valid, m_big, m_small_al, exp_out, swap, op_out);
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_equal_exp();
      send_one(24'h800000, 24'hC00000, 9'd0, 1'b0, 8'h7F, 1'b1);
      n_cmp++;
      if (m_big !== 24'h800000 || m_small_al !== 27'h6000000 || swap !== 1'b0 ||
          exp_out !== 8'h7F || op_out !== 1'b1) begin
         n_err++; $display("FAIL equal_exp: got big=%h al=%h sw=%b e=%h op=%b want 800000 6000000 0 7f 1",
                           m_big, m_small_al, swap, exp_out, op_out);
      end
   endtask

   task automatic test_swap_sticky();
      send_one(24'h800001, 24'hF00000, 9'd4, 1'b1, 8'h85, 1'b0);
      n_cmp++;
      if (m_big !== 24'hF00000 || m_small_al !== 27'h0400001 || exp_out !== 8'h85 ||
          swap !== 1'b1 || op_out !== 1'b0) begin
         n_err++; $display("FAIL swap_sticky: got big=%h al=%h e=%h sw=%b op=%b want f00000 0400001 85 1 0",
                           m_big, m_small_al, exp_out, swap, op_out);
      end
   endtask

   task automatic test_saturation();
      send_one(24'h900000, 24'h800001, 9'd30, 1'b0, 8'h01, 1'b0);
      n_cmp++;
      if (m_small_al !== 27'h0000001 || m_big !== 24'h900000) begin
         n_err++; $display("FAIL sat_d30: got big=%h al=%h want 900000 0000001", m_big, m_small_al);
      end
      send_one(24'h900000, 24'h800001, 9'h1FF, 1'b0, 8'h01, 1'b0);
      n_cmp++;
      if (m_small_al !== 27'h0000001) begin
         n_err++; $display("FAIL sat_d1ff: got al=%h want 0000001", m_small_al);
      end
      send_one(24'h900000, 24'h000000, 9'd27, 1'b0, 8'h01, 1'b0);
      n_cmp++;
      if (m_small_al !== 27'h0) begin
         n_err++; $display("FAIL sat_zero: got al=%h want 0", m_small_al);
      end
      send_one(24'hFFFFFF, 24'hFFFFFF, 9'd26, 1'b0, 8'h01, 1'b0);
      n_cmp++;
      if (m_small_al !== 27'h0000001) begin
         n_err++; $display("FAIL shift_26: got al=%h want 0000001", m_small_al);
      end
   endtask

   task automatic test_back_to_back();
      logic [50:0] e;
      int n_out = 0;
      tick();
      out_ready = 1'b1;
      exp_q.delete();
      for (int c = 0; c < 11; c++) begin
         n_cmp++;
         if (out_valid !== ((c >= 2 && c < 10) ? 1'b1 : 1'b0)) begin
            n_err++; $display("FAIL b2b_valid c=%0d: got %b", c, out_valid);
         end
         if (out_valid === 1'b1) begin
            n_out++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++; $display("FAIL b2b_extra c=%0d: got big=%h with empty queue", c, m_big);
            end else begin
               e = exp_q.pop_front();
               if ({m_big, m_small_al} !== e) begin
                  n_err++; $display("FAIL b2b_data c=%0d: got %h/%h want %h/%h",
                                    c, m_big, m_small_al, e[50:27], e[26:0]);
               end
            end
         end
         if (c < 8) begin
            // ext = 0x4000000 with zero low bits, so no sticky is ever produced here.
            set_in(24'h100000 + 24'(c), 24'h800000, 9'(c), 1'b0, 8'h40, 1'b0);
            in_valid = 1'b1;
            exp_q.push_back({24'h100000 + 24'(c), 27'h4000000 >> c});
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
               n_err++; $display("FAIL b2b_in_ready c=%0d: got %b want 1", c, in_ready);
            end
         end else begin
            in_valid = 1'b0;
         end
         tick();
      end
      n_cmp++;
      if (n_out != 8 || exp_q.size() != 0) begin
         n_err++; $display("FAIL b2b_count: got %0d outputs, %0d left want 8, 0", n_out, exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k == 0)      set_in(24'hA00000, 24'h800000, 9'd1, 1'b0, 8'h10, 1'b1);
         else if (k == 1) set_in(24'h900000, 24'hB00000, 9'd2, 1'b1, 8'h20, 1'b0);
         else             set_in(24'hC00000, 24'hD00000, 9'd3, 1'b0, 8'h30, 1'b1);
         in_valid = 1'b1;
         #1;
         n_cmp++;
         if (in_ready !== ((k < 2) ? 1'b1 : 1'b0)) begin
            n_err++; $display("FAIL bp_in_ready k=%0d: got %b", k, in_ready);
         end
         if (k >= 2) begin
            n_cmp++;
            if (out_valid !== 1'b1 || m_big !== 24'hA00000 || m_small_al !== 27'h2000000 ||
                exp_out !== 8'h10 || swap !== 1'b0 || op_out !== 1'b1) begin
               n_err++; $display("FAIL bp_hold k=%0d: got v=%b big=%h al=%h want 1 a00000 2000000",
                                 k, out_valid, m_big, m_small_al);
            end
         end
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      n_cmp++;
      if (out_valid !== 1'b1 || m_big !== 24'hA00000 || m_small_al !== 27'h2000000) begin
         n_err++; $display("FAIL bp_drain_a: got v=%b big=%h al=%h", out_valid, m_big, m_small_al);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || m_big !== 24'hB00000 || m_small_al !== 27'h1200000 ||
          exp_out !== 8'h20 || swap !== 1'b1 || op_out !== 1'b0) begin
         n_err++; $display("FAIL bp_drain_b: got v=%b big=%h al=%h e=%h sw=%b",
                           out_valid, m_big, m_small_al, exp_out, swap);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL bp_no_dup: got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b0;
      set_in(24'hABCDEF, 24'h800000, 9'd5, 1'b0, 8'h55, 1'b1);
      in_valid = 1'b1;
      tick();
      set_in(24'h123456, 24'hFEDCBA, 9'd7, 1'b1, 8'h66, 1'b1);
      tick();
      rst = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_err++; $display("FAIL rst_in_ready_low: got %b want 0", in_ready);
      end
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || m_big !== 24'h0 || m_small_al !== 27'h0 || exp_out !== 8'h0 ||
          swap !== 1'b0 || op_out !== 1'b0) begin
         n_err++; $display("FAIL rst_mid_outputs: got v=%b big=%h al=%h e=%h sw=%b op=%b want all 0",
                           out_valid, m_big, m_small_al, exp_out, swap, op_out);
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_ghost k=%0d: got out_valid=%b big=%h", k, out_valid, m_big);
         end
      end
   endtask

   initial begin
      test_reset();
      test_equal_exp();
      test_swap_sticky();
      test_saturation();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
